// File: rtl/chunked_adder_sub.sv
// Multi-cycle add/subtract: a WIDTH-bit operand pair is processed CHUNK bits per clock
// through a narrow ripple slice, with the inter-slice carry held in a register.
module chunked_adder_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    int                 base;
    logic [CHUNK:0]     slice_w;
    logic               last_w;
    logic               cin_msb_w;

    always_comb begin
        base      = int'(cnt_q) * CHUNK;
        slice_w   = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};
        last_w    = (cnt_q == CNT_W'(N - 1));
        // Carry into the MSB recovered from the MSB sum bit; only used on the final slice.
        cin_msb_w = slice_w[CHUNK-1] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            RUN: begin
                acc_d[base +: CHUNK] = slice_w[CHUNK-1:0];
                carry_d              = slice_w[CHUNK];
                cnt_d                = cnt_q + CNT_W'(1);
                if (last_w) begin
                    sum_d   = acc_d;
                    cout_d  = slice_w[CHUNK];
                    ovf_d   = cin_msb_w ^ slice_w[CHUNK];
                    state_d = DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request; DONE falls back to IDLE otherwise.
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_adder_sub.sv
// Directed-vector bench for chunked_adder_sub: 16/4 instance for the main cases,
// 8/8 instance for the single-chunk case.
module tb_chunked_adder_sub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    logic        start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    chunked_adder_sub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    chunked_adder_sub #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge; returns at the negedge right after the accepting edge.
    task automatic launch(input logic s, input logic [15:0] x, input logic [15:0] y,
                          input logic c);
        @(negedge clk);
        start = 1'b1; sub = s; a = x; b = y; cin = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done; checks cycles waited, busy cycles seen, and the result.
    task automatic wait_done(input string tag, input int exp_t, input int exp_nb,
                             input logic [15:0] es, input logic ec, input logic eo);
        int t  = 0;
        int nb = 0;
        while (!done && t < 20) begin
            if (busy) nb++;
            @(negedge clk);
            t++;
        end
        check({tag, "_done"},   32'(done), 32'd1);
        check({tag, "_lat"},    32'(t),    32'(exp_t));
        check({tag, "_busy_n"}, 32'(nb),   32'(exp_nb));
        check({tag, "_busy0"},  32'(busy), 32'd0);
        check({tag, "_sum"},    32'(sum),  32'(es));
        check({tag, "_cout"},   32'(cout), 32'(ec));
        check({tag, "_ovf"},    32'(ovf),  32'(eo));
    endtask

    task automatic run_op(input string tag, input logic s, input logic [15:0] x,
                          input logic [15:0] y, input logic c,
                          input logic [15:0] es, input logic ec, input logic eo);
        launch(s, x, y, c);
        wait_done(tag, 4, 4, es, ec, eo);
        @(negedge clk);
        check({tag, "_pulse1"}, 32'(done), 32'd0);
    endtask

    initial begin
        int seen_done;

        // Reset state
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Plain adds and subtracts
        run_op("add_basic", 1'b0, 16'h1234, 16'h0FCC, 1'b0, 16'h2200, 1'b0, 1'b0);
        run_op("add_wrap",  1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0);
        run_op("add_ovf",   1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_neg",   1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        // Start pulsed mid-RUN is ignored
        launch(1'b0, 16'h1234, 16'h0FCC, 1'b0);
        @(negedge clk);
        start = 1'b1; sub = 1'b1; a = 16'h5555; b = 16'h1111; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_sum_held", 32'(sum), 32'hFFFE);
        wait_done("ign", 2, 2, 16'h2200, 1'b0, 1'b0);

        // Start held in DONE: back-to-back acceptance
        start = 1'b1; sub = 1'b1; a = 16'h8000; b = 16'h0001; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done0", 32'(done), 32'd0);
        check("b2b_busy1", 32'(busy), 32'd1);
        check("b2b_hold",  32'(sum),  32'h2200);
        wait_done("b2b", 4, 4, 16'h7FFF, 1'b1, 1'b1);
        @(negedge clk);
        check("b2b_idle", 32'(busy), 32'd0);

        // Reset mid-RUN aborts
        launch(1'b0, 16'h7FFF, 16'h0001, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_sum",  32'(sum),  32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf",  32'(ovf),  32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        seen_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) seen_done = 1;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        run_op("post_rst", 1'b0, 16'h1234, 16'h0FCC, 1'b0, 16'h2200, 1'b0, 1'b0);

        // Single-chunk instance
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hF0; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        check("w8_busy",  32'(busy8), 32'd1);
        check("w8_done0", 32'(done8), 32'd0);
        @(negedge clk);
        check("w8_done",  32'(done8), 32'd1);
        check("w8_sum",   32'(sum8),  32'h10);
        check("w8_cout",  32'(cout8), 32'd1);
        check("w8_ovf",   32'(ovf8),  32'd0);
        @(negedge clk);
        check("w8_pulse1", 32'(done8), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
